// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants and types for the register-file writeback path.
//            Contents: XLEN, REG_AW, REG_ZERO and the wb_req_t {rd, data}
//            request record.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Purpose  : Valid/ready bundle between NREQ writeback sources and the
//            register-file write arbiter.
//            req_valid [NREQ]      source i has a write pending
//            req_ready [NREQ]      source i accepted this cycle
//            req_rd    [NREQ*AW]   destination register of source i
//            req_data  [NREQ*XLEN] write data of source i
//            master : writeback sources, slave : arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    output req_ready
  );

endinterface : regfile_wb_arbiter_if
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Purely combinational round-robin arbiter. The search starts at
//            index ptr and wraps N-1 -> 0; the first requesting index wins.
//            req     [N]   request vector
//            ptr     [IW]  highest-priority index (0..N-1)
//            gnt     [N]   one-hot grant (zero when nothing requests)
//            gnt_idx [IW]  binary index of the grant (0 when no grant)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // Rotate requests so that the ptr position lands on bit 0; a plain
  // lowest-bit-first priority pick then implements the round-robin order.
  logic [2*N-1:0] w_req_dbl;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;
  logic [N:0]     w_seen;
  logic [2*N-1:0] w_gnt_dbl;
  logic [IW-1:0]  w_idx_chain [0:N];

  assign w_req_dbl = {req, req};
  assign w_rot     = N'(w_req_dbl >> ptr);
  assign w_seen[0] = 1'b0;

  for (genvar k = 0; k < N; k++) begin : g_pick
    assign w_first[k]  = w_rot[k] & ~w_seen[k];
    assign w_seen[k+1] = w_seen[k] | w_rot[k];
  end

  // Rotate the pick back into requester order.
  assign w_gnt_dbl = {w_first, w_first} << ptr;
  assign gnt       = w_gnt_dbl[2*N-1:N];

  assign w_idx_chain[0] = '0;
  for (genvar i = 0; i < N; i++) begin : g_encode
    assign w_idx_chain[i+1] = w_idx_chain[i] | (gnt[i] ? IW'(i) : '0);
  end
  assign gnt_idx = w_idx_chain[N];

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the single register-file write port between NREQ
//            writeback sources. Round-robin grant, one write per cycle,
//            registered output stage, writes to x0 consumed but suppressed.
//            clk, reset      clock / synchronous active-high reset
//            wb (slave)      requester valid/ready/rd/data bundle
//            flush           drop the write stage, block grants this cycle
//            rf_we/rf_rd/rf_wdata  register-file write port
//            busy            rf_we or any request pending
//            Optional (macro WB_FWD_EN): rs1, rs2 in; fwd1_hit, fwd2_hit,
//            fwd_data out - bypass of the write not yet in the register file.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int AW   = regfile_pkg::REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic                flush,
  output logic                rf_we,
  output logic [AW-1:0]       rf_rd,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                busy
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]       rs1,
  input  logic [AW-1:0]       rs2,
  output logic                fwd1_hit,
  output logic                fwd2_hit,
  output logic [XLEN-1:0]     fwd_data
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_accept;
  logic [AW-1:0]   w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic [IW-1:0]   w_ptr_next;

  // Reset and flush both mask every request, so no ready is raised and the
  // requesters simply retry on a later cycle.
  assign w_req = (reset || flush) ? '0 : wb.req_valid;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr_arbiter (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign wb.req_ready = w_gnt;
  assign w_accept     = |w_gnt;

  assign w_sel_rd   = AW'(wb.req_rd >> (w_gnt_idx * AW));
  assign w_sel_data = XLEN'(wb.req_data >> (w_gnt_idx * XLEN));
  assign w_ptr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      rf_rd    <= w_sel_rd;
      rf_wdata <= w_sel_data;
      rf_we    <= (w_sel_rd != AW'(REG_ZERO));
      r_rr_ptr <= w_ptr_next;
    end else begin
      // rf_rd / rf_wdata / pointer hold; only the write strobe drops.
      rf_we <= 1'b0;
    end
  end

  assign busy = rf_we | (|wb.req_valid);

`ifdef WB_FWD_EN
  assign fwd1_hit = rf_we && (rf_rd == rs1) && (rs1 != AW'(REG_ZERO));
  assign fwd2_hit = rf_we && (rf_rd == rs2) && (rs2 != AW'(REG_ZERO));
  assign fwd_data = rf_wdata;
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter with two
//            requesters. Optional forwarding checks under WB_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 2;
  localparam int XW   = 64;
  localparam int AW   = 5;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XW-1:0]   rf_wdata;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Value that would land in x0 if a write to it ever reached the file.
  logic [XW-1:0] x0_val = '0;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XW), .AW(AW)) wb ();

`ifdef WB_FWD_EN
  logic [AW-1:0] rs1 = '0;
  logic [AW-1:0] rs2 = '0;
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [XW-1:0] fwd_data;
`endif

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XW), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb),
    .flush    (flush),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wdata (rf_wdata),
    .busy     (busy)
`ifdef WB_FWD_EN
    ,
    .rs1      (rs1),
    .rs2      (rs2),
    .fwd1_hit (fwd1_hit),
    .fwd2_hit (fwd2_hit),
    .fwd_data (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we && rf_rd == 5'd0) x0_val <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic [4:0] rd, input logic [63:0] d);
    wb_req_t r;
    r.rd   = rd;
    r.data = d;
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input wb_req_t r0, input wb_req_t r1);
    wb.req_valid = v;
    wb.req_rd    = {r1.rd, r0.rd};
    wb.req_data  = {r1.data, r0.data};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt [4];
  logic [4:0] exp_rd  [4];

  initial begin
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rd  = '{5'd1, 5'd2, 5'd1, 5'd2};

    // Reset: outputs cleared and no ready even with requests pending.
    drive(2'b11, mk(5'd1, 64'h1), mk(5'd2, 64'h2));
    tick();
    tick();
    chk("rst_ready",  64'(wb.req_ready), 64'h0);
    chk("rst_we",     64'(rf_we),        64'h0);
    chk("rst_rd",     64'(rf_rd),        64'h0);
    chk("rst_wdata",  rf_wdata,          64'h0);
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    reset = 1'b0;
    tick();

    // Single source: req0 rd=5 data=0xAB for one cycle.
    drive(2'b01, mk(5'd5, 64'hAB), mk(5'd0, 64'h0));
    #1;
    chk("t1_ready", 64'(wb.req_ready), 64'h1);
    chk("t1_busy",  64'(busy),         64'h1);
    tick();
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("t1_we",    64'(rf_we),  64'h1);
    chk("t1_rd",    64'(rf_rd),  64'h5);
    chk("t1_wdata", rf_wdata,    64'hAB);
    tick();
    chk("t1_we_off",  64'(rf_we), 64'h0);
    chk("t1_rd_hold", 64'(rf_rd), 64'h5);
    chk("t1_idle",    64'(busy),  64'h0);

    // x0 write from req1 (pointer is at 1): consumed, never written.
    drive(2'b10, mk(5'd0, 64'h0), mk(5'd0, 64'hFF));
    #1;
    chk("x0_ready", 64'(wb.req_ready), 64'h2);
    tick();
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("x0_we",    64'(rf_we), 64'h0);
    chk("x0_wdata", rf_wdata,   64'hFF);
    tick();
    chk("x0_reads_zero", x0_val, 64'h0);

    // Both valid for four cycles: alternate grants, no idle cycles.
    drive(2'b11, mk(5'd1, 64'h1111), mk(5'd2, 64'h2222));
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_gnt%0d", i), 64'(wb.req_ready), 64'(exp_gnt[i]));
      if (i > 0) begin
        chk($sformatf("rr_we%0d", i), 64'(rf_we), 64'h1);
        chk($sformatf("rr_rd%0d", i), 64'(rf_rd), 64'(exp_rd[i-1]));
      end
      tick();
    end
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("rr_we_last",    64'(rf_we), 64'h1);
    chk("rr_rd_last",    64'(rf_rd), 64'h2);
    chk("rr_wdata_last", rf_wdata,   64'h2222);

    // Flush with req0 valid: no ready, write stage dropped, retry next cycle.
    flush = 1'b1;
    drive(2'b01, mk(5'd3, 64'h33), mk(5'd0, 64'h0));
    #1;
    chk("fl_ready", 64'(wb.req_ready), 64'h0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_we",    64'(rf_we),        64'h0);
    chk("fl_retry", 64'(wb.req_ready), 64'h1);
    tick();
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("fl_we2", 64'(rf_we), 64'h1);
    chk("fl_rd2", 64'(rf_rd), 64'h3);

    // Reset while rf_we=1 and the pointer sits at 1: pointer returns to 0.
    reset = 1'b1;
    drive(2'b11, mk(5'd1, 64'h1111), mk(5'd2, 64'h2222));
    #1;
    chk("mr_ready", 64'(wb.req_ready), 64'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_we",    64'(rf_we),        64'h0);
    chk("mr_rd",    64'(rf_rd),        64'h0);
    chk("mr_wdata", rf_wdata,          64'h0);
    chk("mr_gnt0",  64'(wb.req_ready), 64'h1);
    tick();
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("mr_we2", 64'(rf_we), 64'h1);
    chk("mr_rd2", 64'(rf_rd), 64'h1);
    tick();
    chk("mr_idle", 64'(busy), 64'h0);

`ifdef WB_FWD_EN
    // Forwarding: rf_we=1 rf_rd=7 rf_wdata=0x55, rs1=7, rs2=0.
    drive(2'b01, mk(5'd7, 64'h55), mk(5'd0, 64'h0));
    rs1 = 5'd7;
    rs2 = 5'd0;
    tick();
    drive(2'b00, mk(5'd0, 64'h0), mk(5'd0, 64'h0));
    #1;
    chk("fwd1_hit", 64'(fwd1_hit), 64'h1);
    chk("fwd2_hit", 64'(fwd2_hit), 64'h0);
    chk("fwd_data", fwd_data,      64'h55);
    rs2 = 5'd7;
    #1;
    chk("fwd2_hit_b", 64'(fwd2_hit), 64'h1);
    tick();
    chk("fwd1_off", 64'(fwd1_hit), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
